// File: rtl/fetch_if.sv
// Bundle of the fetch stage's control, memory-read and inner-interpreter
// signals. master is the fetch stage itself; slave is the surrounding system.
interface fetch_if #(
    parameter int DSZ = 8,
    parameter int ASZ = 17
);
    logic           go;
    logic [ASZ-1:0] cfa;
    logic           mem_rd;
    logic [ASZ-1:0] mem_addr;
    logic [DSZ-1:0] mem_dat;
    logic           ex_en;
    logic [DSZ-1:0] ex_op;
    logic [ASZ-1:0] ex_pfa;
    logic           ex_bsy;
    logic           bsy;
    logic           done;
    logic           err;
    logic [ASZ-1:0] ip;
    logic [7:0]     cnt;

    modport master (
        input  go, cfa, mem_dat, ex_bsy,
        output mem_rd, mem_addr, ex_en, ex_op, ex_pfa, bsy, done, err, ip, cnt
    );

    modport slave (
        output go, cfa, mem_dat, ex_bsy,
        input  mem_rd, mem_addr, ex_en, ex_op, ex_pfa, bsy, done, err, ip, cnt
    );
endinterface

// File: rtl/fetch.sv
// Byte-code fetch/dispatch stage: walks a threaded opcode list from cfa and
// hands each opcode to the inner interpreter until EXIT, timeout or overrun.
module fetch #(
    parameter int                unsigned DSZ     = 8,
    parameter int                unsigned ASZ     = 17,
    parameter logic [DSZ-1:0]             OP_EXIT = 8'h00,
    parameter int                unsigned TMO     = 16,
    parameter int                unsigned MAXN    = 255
) (
    input logic    clk,
    input logic    rst_n,
    fetch_if.master bus
);
    localparam int unsigned TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WT, S_DSP, S_EXW, S_NXT, S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [ASZ-1:0] ip_q, ip_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           ex_en_q, ex_en_d;
    logic [DSZ-1:0] ex_op_q, ex_op_d;
    logic [ASZ-1:0] ex_pfa_q, ex_pfa_d;
    logic           mem_rd_q, mem_rd_d;
    logic [ASZ-1:0] mem_addr_q, mem_addr_d;
    logic           bsy_q, bsy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ip_q       <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            ex_en_q    <= 1'b0;
            ex_op_q    <= '0;
            ex_pfa_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            bsy_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            ex_en_q    <= ex_en_d;
            ex_op_q    <= ex_op_d;
            ex_pfa_q   <= ex_pfa_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            bsy_q      <= bsy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Outputs are registered, so the FIN-cycle values (pulse, bsy/ex_en low)
    // are loaded on the edge that enters FIN and dropped on the edge leaving it.
    always_comb begin
        state_d    = state_q;
        ip_d       = ip_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        ex_en_d    = ex_en_q;
        ex_op_d    = ex_op_q;
        ex_pfa_d   = ex_pfa_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        bsy_d      = bsy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    ip_d       = bus.cfa;
                    cnt_d      = '0;
                    bsy_d      = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = bus.cfa;
                    state_d    = S_RD;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                if (bus.mem_dat == OP_EXIT) begin
                    bsy_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (cnt_q == 8'(MAXN)) begin
                    bsy_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    ex_op_d  = bus.mem_dat;
                    ex_pfa_d = ip_q + ASZ'(1);
                    ex_en_d  = 1'b1;
                    timer_d  = '0;
                    state_d  = S_DSP;
                end
            end
            S_DSP, S_EXW: begin
                timer_d = timer_q + TW'(1);
                if (state_q == S_DSP && bus.ex_bsy) begin
                    state_d = S_EXW;
                end else if (state_q == S_EXW && !bus.ex_bsy) begin
                    ex_en_d = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_NXT;
                end else if (timer_q == TW'(TMO - 1)) begin
                    ex_en_d = 1'b0;
                    bsy_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_NXT: begin
                ip_d       = ip_q + ASZ'(1);
                mem_rd_d   = 1'b1;
                mem_addr_d = ip_q + ASZ'(1);
                state_d    = S_RD;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.ex_en    = ex_en_q;
    assign bus.ex_op    = ex_op_q;
    assign bus.ex_pfa   = ex_pfa_q;
    assign bus.bsy      = bsy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.ip       = ip_q;
    assign bus.cnt      = cnt_q;
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: byte memory and inner-interpreter models drive the DUT,
// results are compared against a list walk computed directly from memory.
module tb_fetch;
    localparam int ASZ  = 17;
    localparam int TMO  = 16;
    localparam int MAXN = 4;

    typedef struct packed {
        logic [7:0]     op;
        logic [ASZ-1:0] pfa;
    } disp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_if #(.DSZ(8), .ASZ(ASZ)) bus ();

    fetch #(.DSZ(8), .ASZ(ASZ), .OP_EXIT(8'h00), .TMO(TMO), .MAXN(MAXN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0] mem [0:(1<<ASZ)-1];
    int n_checks = 0;
    int n_pass   = 0;

    // memory: data returned the cycle after the read strobe, junk otherwise
    always @(posedge clk) begin
        logic rd;
        logic [ASZ-1:0] a;
        rd = bus.mem_rd;
        a  = bus.mem_addr;
        #1 bus.mem_dat = rd ? mem[a] : 8'($urandom);
    end

    // inner interpreter: busy for busy_len cycles once ex_en is seen
    int    busy_len   = 3;
    bit    never_busy = 1'b0;
    int    istate     = 0;
    int    rem        = 0;
    disp_t seen[$];
    always @(posedge clk) begin
        logic  en;
        disp_t d;
        en    = bus.ex_en;
        d.op  = bus.ex_op;
        d.pfa = bus.ex_pfa;
        #1;
        if (!rst_n) begin
            istate     = 0;
            bus.ex_bsy = 1'b0;
        end else begin
            case (istate)
                0: if (en && !never_busy) begin
                    seen.push_back(d);
                    bus.ex_bsy = 1'b1;
                    rem        = busy_len;
                    istate     = 1;
                end
                1: begin
                    rem--;
                    if (rem == 0) begin
                        bus.ex_bsy = 1'b0;
                        istate     = 2;
                    end
                end
                default: if (!en) istate = 0;
            endcase
        end
    end

    // protocol watch: ex_op/ex_pfa stable under ex_en, done/err exclusive
    int viol = 0;
    logic pen = 1'b0;
    logic [7:0] pop;
    logic [ASZ-1:0] ppfa;
    always @(negedge clk) begin
        if (bus.ex_en && pen && (bus.ex_op !== pop || bus.ex_pfa !== ppfa)) viol++;
        if (bus.done === 1'b1 && bus.err === 1'b1) viol++;
        pen  = bus.ex_en;
        pop  = bus.ex_op;
        ppfa = bus.ex_pfa;
    end

    // reference walk of the list as stored in mem
    disp_t          exp_q[$];
    int             exp_cnt;
    logic [ASZ-1:0] exp_ip;
    bit             exp_err;
    function automatic void model_walk(input logic [ASZ-1:0] cfa);
        logic [ASZ-1:0] p;
        disp_t d;
        p = cfa;
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        while (1) begin
            if (mem[p] == 8'h00) break;
            if (exp_cnt == MAXN) begin
                exp_err = 1'b1;
                break;
            end
            d.op  = mem[p];
            d.pfa = p + 1'b1;
            exp_q.push_back(d);
            exp_cnt++;
            p = p + 1'b1;
        end
        exp_ip = p;
    endfunction

    bit             fin_done, fin_err, fin_bsy, fin_en, fin_next, tmo_hit;
    logic [7:0]     fin_cnt;
    logic [ASZ-1:0] fin_ip;
    int             cycles;

    task automatic run_list(input logic [ASZ-1:0] cfa, input bit poke_go);
        seen.delete();
        @(posedge clk); #1;
        bus.go  = 1'b1;
        bus.cfa = cfa;
        cycles  = 0;
        tmo_hit = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            cycles++;
            bus.go  = poke_go && cycles == 6;
            bus.cfa = ASZ'($urandom);
            if (bus.done || bus.err) begin
                tmo_hit  = 1'b0;
                fin_done = bus.done;
                fin_err  = bus.err;
                fin_bsy  = bus.bsy;
                fin_en   = bus.ex_en;
                fin_cnt  = bus.cnt;
                fin_ip   = bus.ip;
                break;
            end
        end
        bus.go = 1'b0;
        @(posedge clk); #1;
        fin_next = bus.done || bus.err;
    endtask

    task automatic test_reset();
        logic [2*ASZ+ASZ+ASZ+8+8+5-1:0] outs;
        rst_n   = 1'b0;
        bus.go  = 1'b0;
        bus.cfa = '0;
        repeat (3) @(posedge clk);
        #1;
        outs = {bus.mem_rd, bus.mem_addr, bus.ex_en, bus.ex_op, bus.ex_pfa,
                bus.bsy, bus.done, bus.err, bus.ip, bus.cnt};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_outputs got %h want 0", outs); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] ops[3] = '{8'h11, 8'h22, 8'h33};
        mem[17'h100] = 8'h11; mem[17'h101] = 8'h22; mem[17'h102] = 8'h33; mem[17'h103] = 8'h00;
        busy_len = 3;
        run_list(17'h100, 1'b0);
        n_checks++; if (tmo_hit)       $display("FAIL basic_finish no done/err within bound"); else n_pass++;
        n_checks++; if (seen.size() !== 3) $display("FAIL basic_ndisp got %0d want 3", seen.size()); else n_pass++;
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            n_checks++;
            if (seen[i].op !== ops[i] || seen[i].pfa !== ASZ'(17'h101 + i))
                $display("FAIL basic_disp%0d got op=%h pfa=%h want op=%h pfa=%h",
                         i, seen[i].op, seen[i].pfa, ops[i], 17'h101 + i);
            else n_pass++;
        end
        n_checks++; if ({fin_done, fin_err} !== 2'b10) $display("FAIL basic_done got done=%b err=%b want 1/0", fin_done, fin_err); else n_pass++;
        n_checks++; if (fin_cnt !== 8'd3)     $display("FAIL basic_cnt got %0d want 3", fin_cnt); else n_pass++;
        n_checks++; if (fin_ip !== 17'h103)   $display("FAIL basic_ip got %h want 103", fin_ip); else n_pass++;
        n_checks++; if (cycles !== 27)        $display("FAIL basic_latency got %0d want 27", cycles); else n_pass++;
        n_checks++; if (fin_next !== 1'b0)    $display("FAIL basic_pulse got %b want 0", fin_next); else n_pass++;
    endtask

    task automatic test_immediate_exit();
        mem[17'h200] = 8'h00;
        run_list(17'h200, 1'b0);
        n_checks++; if (tmo_hit)              $display("FAIL exit_finish no done within bound"); else n_pass++;
        n_checks++; if (seen.size() !== 0)    $display("FAIL exit_ndisp got %0d want 0", seen.size()); else n_pass++;
        n_checks++; if ({fin_done, fin_err} !== 2'b10) $display("FAIL exit_done got done=%b err=%b want 1/0", fin_done, fin_err); else n_pass++;
        n_checks++; if (cycles !== 3)         $display("FAIL exit_latency got %0d want 3", cycles); else n_pass++;
        n_checks++; if (fin_cnt !== 8'd0)     $display("FAIL exit_cnt got %0d want 0", fin_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        int k;
        bit seen_en;
        bit seen_err;
        never_busy = 1'b1;
        mem[17'h500] = 8'h77; mem[17'h501] = 8'h00;
        @(posedge clk); #1;
        bus.go  = 1'b1;
        bus.cfa = 17'h500;
        seen_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            bus.go = 1'b0;
            if (bus.ex_en) begin seen_en = 1'b1; break; end
        end
        n_checks++; if (!seen_en) $display("FAIL tmo_ex_en never asserted"); else n_pass++;
        k = 0;
        seen_err = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            k++;
            if (bus.err || bus.done) begin seen_err = bus.err; break; end
        end
        n_checks++; if (!seen_err)            $display("FAIL tmo_err no err pulse"); else n_pass++;
        n_checks++; if (k !== TMO)            $display("FAIL tmo_latency got %0d want %0d", k, TMO); else n_pass++;
        n_checks++; if ({bus.ex_en, bus.bsy, bus.done} !== 3'b000)
                        $display("FAIL tmo_state got en/bsy/done=%b%b%b want 000", bus.ex_en, bus.bsy, bus.done); else n_pass++;
        n_checks++; if (bus.cnt !== 8'd0)     $display("FAIL tmo_cnt got %0d want 0", bus.cnt); else n_pass++;
        never_busy = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 5; i++) mem[17'h300 + i] = 8'($urandom_range(1, 255));
        mem[17'h305] = 8'h00;
        busy_len = 2;
        run_list(17'h300, 1'b0);
        n_checks++; if (tmo_hit)              $display("FAIL ovr_finish no err within bound"); else n_pass++;
        n_checks++; if (seen.size() !== 4)    $display("FAIL ovr_ndisp got %0d want 4", seen.size()); else n_pass++;
        n_checks++; if ({fin_done, fin_err} !== 2'b01) $display("FAIL ovr_err got done=%b err=%b want 0/1", fin_done, fin_err); else n_pass++;
        n_checks++; if (fin_cnt !== 8'd4)     $display("FAIL ovr_cnt got %0d want 4", fin_cnt); else n_pass++;
        n_checks++; if (fin_ip !== 17'h304)   $display("FAIL ovr_ip got %h want 304", fin_ip); else n_pass++;
        n_checks++; if (cycles !== 4*(2+5)+3) $display("FAIL ovr_latency got %0d want %0d", cycles, 4*7+3); else n_pass++;
    endtask

    task automatic test_wrap();
        mem[17'h1FFFF] = 8'h55;
        mem[17'h00000] = 8'h00;
        busy_len = 1;
        run_list(17'h1FFFF, 1'b0);
        n_checks++; if (tmo_hit)              $display("FAIL wrap_finish no done within bound"); else n_pass++;
        n_checks++; if (seen.size() !== 1 || seen[0].op !== 8'h55 || seen[0].pfa !== 17'h0)
                        $display("FAIL wrap_disp got n=%0d op=%h pfa=%h want n=1 op=55 pfa=0",
                                 seen.size(), seen.size() > 0 ? seen[0].op : 8'hxx,
                                 seen.size() > 0 ? seen[0].pfa : 17'hx); else n_pass++;
        n_checks++; if ({fin_done, fin_err, fin_cnt} !== {2'b10, 8'd1})
                        $display("FAIL wrap_done got done=%b err=%b cnt=%0d want 1/0/1", fin_done, fin_err, fin_cnt); else n_pass++;
        n_checks++; if (fin_ip !== 17'h0)     $display("FAIL wrap_ip got %h want 0", fin_ip); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [ASZ-1:0] cfa;
        int len;
        for (int it = 0; it < 8; it++) begin
            cfa = ASZ'($urandom_range(17'h1000, 17'h1F000));
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) mem[cfa + ASZ'(i)] = 8'($urandom_range(1, 255));
            mem[cfa + ASZ'(len)] = 8'h00;
            busy_len = $urandom_range(1, 8);
            model_walk(cfa);
            run_list(cfa, 1'($urandom_range(0, 1)));
            n_checks++; if (tmo_hit) $display("FAIL rnd%0d_finish no done/err within bound", it); else n_pass++;
            n_checks++; if (seen !== exp_q)
                            $display("FAIL rnd%0d_disp got n=%0d want n=%0d", it, seen.size(), exp_q.size()); else n_pass++;
            n_checks++; if ({fin_done, fin_err} !== {!exp_err, exp_err})
                            $display("FAIL rnd%0d_status got done=%b err=%b want %b/%b", it, fin_done, fin_err, !exp_err, exp_err); else n_pass++;
            n_checks++; if (fin_cnt !== 8'(exp_cnt) || fin_ip !== exp_ip)
                            $display("FAIL rnd%0d_cnt_ip got cnt=%0d ip=%h want cnt=%0d ip=%h", it, fin_cnt, fin_ip, exp_cnt, exp_ip); else n_pass++;
            n_checks++; if (cycles !== exp_cnt*(busy_len+5)+3 || fin_bsy || fin_en)
                            $display("FAIL rnd%0d_timing got cyc=%0d bsy=%b en=%b want cyc=%0d bsy=0 en=0",
                                     it, cycles, fin_bsy, fin_en, exp_cnt*(busy_len+5)+3); else n_pass++;
        end
        n_checks++; if (viol !== 0) $display("FAIL protocol_watch got %0d violations want 0", viol); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit in_exw;
        bit pulsed;
        mem[17'h600] = 8'h41; mem[17'h601] = 8'h42; mem[17'h602] = 8'h00;
        busy_len = 10;
        @(posedge clk); #1;
        bus.go  = 1'b1;
        bus.cfa = 17'h600;
        in_exw  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            bus.go = 1'b0;
            if (bus.ex_bsy && bus.ex_en) begin in_exw = 1'b1; break; end
        end
        n_checks++; if (!in_exw) $display("FAIL arst_reach_exw inner never busy"); else n_pass++;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.ex_en, bus.bsy, bus.ip} !== '0)
                        $display("FAIL arst_clear got en=%b bsy=%b ip=%h want 0/0/0", bus.ex_en, bus.bsy, bus.ip); else n_pass++;
        pulsed = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done || bus.err) pulsed = 1'b1;
        end
        n_checks++; if (pulsed) $display("FAIL arst_no_pulse got done/err pulse want none"); else n_pass++;
        @(negedge clk);
        rst_n    = 1'b1;
        busy_len = 3;
        model_walk(17'h100);
        run_list(17'h100, 1'b1);
        n_checks++; if (tmo_hit || seen !== exp_q || fin_cnt !== 8'(exp_cnt) || !fin_done || fin_ip !== exp_ip)
                        $display("FAIL arst_restart got n=%0d cnt=%0d done=%b ip=%h want n=%0d cnt=%0d done=1 ip=%h",
                                 seen.size(), fin_cnt, fin_done, fin_ip, exp_q.size(), exp_cnt, exp_ip); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_immediate_exit();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
